// File: rtl/alu_issue_pkg.sv
// Shared opcode/ALU encodings, ID/EX payload layout and the writeback bypass helper
// for the alu_issue operand-issue stage.
package alu_issue_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned OPC_W  = 7;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

  localparam logic [F3_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [F3_W-1:0] ALU_SLL  = 3'b001;
  localparam logic [F3_W-1:0] ALU_SLT  = 3'b010;
  localparam logic [F3_W-1:0] ALU_SLTU = 3'b011;
  localparam logic [F3_W-1:0] ALU_XOR  = 3'b100;
  localparam logic [F3_W-1:0] ALU_SRX  = 3'b101;
  localparam logic [F3_W-1:0] ALU_OR   = 3'b110;
  localparam logic [F3_W-1:0] ALU_AND  = 3'b111;

  localparam logic [XLEN_W-1:0] LINK_OFFSET = 32'd4;

  typedef struct packed {
    logic [XLEN_W-1:0] op1;
    logic [XLEN_W-1:0] op2;
    logic [F3_W-1:0]   funct3;
    logic              is_sub_sra;
    logic [REG_W-1:0]  rd;
    logic              illegal;
  } issue_t;

  localparam int unsigned ISSUE_W = $bits(issue_t);

  // Source operand with x0 hardwired to zero and same-cycle writeback forwarding.
  function automatic logic [XLEN_W-1:0] src_value(
    input logic [REG_W-1:0]  rs,
    input logic [XLEN_W-1:0] rs_val,
    input logic              wb_en,
    input logic [REG_W-1:0]  wb_rd,
    input logic [XLEN_W-1:0] wb_data
  );
    logic [XLEN_W-1:0] v;
    v = rs_val;
    if (rs == REG_W'(0))
      v = '0;
    else if (wb_en && (wb_rd == rs))
      v = wb_data;
    return v;
  endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Generic two-entry FIFO skid buffer with synchronous flush; in_ready is registered
// and deasserts once both entries are occupied.
module alu_issue_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         rdy_q;
  logic         push;
  logic         pop;

  assign push      = in_valid && rdy_q && !flush;
  assign pop       = (count_q != 2'd0) && out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 2'd1;
    else if (!push && pop)
      count_d = count_q - 2'd1;
  end

  // Head is always the oldest entry; tail only fills when the head is occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      rdy_q   <= 1'b1;
    end else if (flush) begin
      count_q <= 2'd0;
      rdy_q   <= 1'b1;
    end else begin
      count_q <= count_d;
      rdy_q   <= (count_d != 2'd2);
      if (pop && (count_q == 2'd2))
        head_q <= tail_q;
      else if (push && ((count_q == 2'd0) || pop))
        head_q <= in_data;
      if (push && (((count_q == 2'd1) && !pop) || ((count_q == 2'd2) && pop)))
        tail_q <= in_data;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage ahead of the integer ALU: bypass, operand select, ID/EX register.
// Define ALU_ISSUE_SKID_EN to replace the single ID/EX register with a 2-entry skid buffer.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [2:0]      funct3,
  output logic            is_sub_sra,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  issue_t            nxt;
  issue_t            held;
  logic              held_valid;
  logic [XLEN_W-1:0] rs1_v;
  logic [XLEN_W-1:0] rs2_v;

  assign rs1_v = src_value(in_rs1, in_rs1_val, wb_en, wb_rd, wb_data);
  assign rs2_v = src_value(in_rs2, in_rs2_val, wb_en, wb_rd, wb_data);

  // Operand selection; unknown opcodes become a zero-operand, no-write marker.
  always_comb begin
    nxt            = '0;
    nxt.funct3     = ALU_ADD;
    nxt.rd         = in_rd;
    case (in_opcode)
      OPC_OP: begin
        nxt.op1        = rs1_v;
        nxt.op2        = rs2_v;
        nxt.funct3     = in_funct3;
        nxt.is_sub_sra = in_funct7b5 && ((in_funct3 == ALU_ADD) || (in_funct3 == ALU_SRX));
      end
      OPC_OP_IMM: begin
        nxt.op1        = rs1_v;
        nxt.op2        = in_imm;
        nxt.funct3     = in_funct3;
        nxt.is_sub_sra = in_funct7b5 && (in_funct3 == ALU_SRX);
      end
      OPC_LUI: begin
        nxt.op2 = in_imm;
      end
      OPC_AUIPC: begin
        nxt.op1 = in_pc;
        nxt.op2 = in_imm;
      end
      OPC_JAL, OPC_JALR: begin
        nxt.op1 = in_pc;
        nxt.op2 = LINK_OFFSET;
      end
      default: begin
        nxt.rd      = '0;
        nxt.illegal = 1'b1;
      end
    endcase
  end

`ifdef ALU_ISSUE_SKID_EN
  logic skid_ready;

  alu_issue_skid #(
    .W(ISSUE_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (skid_ready),
    .in_data   (nxt),
    .out_valid (held_valid),
    .out_ready (out_ready),
    .out_data  (held)
  );

  assign in_ready = skid_ready && !flush && !rst;
`else
  issue_t idex_q;
  logic   idex_valid_q;

  assign in_ready   = !rst && !flush && (out_ready || !idex_valid_q);
  assign held       = idex_q;
  assign held_valid = idex_valid_q;

  // Payload loads only on accept, so a stalled entry keeps its captured operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q       <= '0;
      idex_valid_q <= 1'b0;
    end else if (flush) begin
      idex_valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      idex_q       <= nxt;
      idex_valid_q <= 1'b1;
    end else if (idex_valid_q && out_ready) begin
      idex_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid   = held_valid;
  assign op1         = held.op1;
  assign op2         = held.op2;
  assign funct3      = held.funct3;
  assign is_sub_sra  = held.is_sub_sra;
  assign out_rd      = held.rd;
  assign out_illegal = held.illegal;

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-issue stage directly upstream of the integer ALU. Accepts decoded RV32I integer instructions over a valid/ready handshake and selects op1/op2. Bypasses a same-cycle writeback value, derives funct3/is_sub_sra, and holds the result in an ID/EX pipeline register. The combinational ALU consumes that register, and the downstream EX/WB register pops it.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  single clock; all state rises on posedge clk
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries (redirect)
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_opcode  in  7  instruction[6:0]
- in_funct3  in  3  instruction[14:12]
- in_funct7b5  in  1  instruction[30]
- in_rs1, in_rs2, in_rd  in  5 each  register indices
- in_rs1_val, in_rs2_val  in  32 each  regfile read data
- in_imm  in  32  sign/shift-extended immediate from decode
- in_pc  in  32  instruction PC
- wb_en  in  1  writeback port write enable
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback data
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  downstream consumes this cycle
- op1, op2  out  32 each  ALU operands
- funct3  out  3  ALU function select, encoded like ALU_ADD..ALU_AND
- is_sub_sra  out  1  ALU SUB/SRA modifier
- out_rd  out  5  destination register; 0 when no write
- out_illegal  out  1  unsupported opcode marker

## Operation
- Accept when in_valid && in_ready and flush is low. Consume when out_valid && out_ready.
- Bypass at accept: for each source rsN, if wb_en && wb_rd==rsN && rsN!=0, use wb_data; otherwise use in_rsN_val. Index x0 always reads 0.
- Operand selection:
  - OP (0110011): op1=rs1, op2=rs2, funct3=in_funct3. is_sub_sra=in_funct7b5 when funct3 is ADD or SRX, else 0.
  - OP-IMM (0010011): op1=rs1, op2=imm, funct3=in_funct3. is_sub_sra=in_funct7b5 only when funct3 is SRX, else 0, so ADDI never subtracts.
  - LUI (0110111): op1=0, op2=imm, funct3=ADD, is_sub_sra=0.
  - AUIPC (0010111): op1=pc, op2=imm, funct3=ADD.
  - JAL (1101111) / JALR (1100111): op1=pc, op2=32'd4, funct3=ADD, producing the link value.
  - Any other opcode: out_illegal=1, op1=op2=0, funct3=ADD, out_rd=0.
- All arithmetic is 32-bit with wrap-around. No widths are extended beyond 32.
- flush: clears every held entry at the next edge. An input offered in the flush cycle is not accepted (in_ready is forced low).

## Timing
- Latency: 1 cycle from accept to out_valid. Throughput is 1 instruction/cycle when out_ready stays high.
- Reset values: out_valid=0; op1, op2, funct3, is_sub_sra, out_rd and out_illegal all 0. in_ready=1 after rst deasserts, and in_ready=0 while rst is high.
- Outputs are stable while out_valid && !out_ready. The payload changes only on a consume or on an empty-to-full transition.
- If a stalled entry already holds the bypassed value, a later wb to the same rd does not update it. Decode guarantees hazard freedom beyond this same-cycle bypass.
- Simultaneous accept and consume: the entry is replaced in the same edge with no bubble.
- Reset mid-operation clears everything immediately and asynchronously. Any accepted instruction is lost.

## Configuration
- ALU_ISSUE_SKID_EN defined:
  - A 2-entry skid buffer is inserted and in_ready is a registered signal, equal to !skid_full.
  - At most one extra instruction is accepted after out_ready falls.
  - The skid entry drains first-in-first-out.
- ALU_ISSUE_SKID_EN undefined:
  - A single register is used, with in_ready = !flush && (out_ready || !out_valid), driven combinationally from out_ready.

## Structure
- Opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR) and the ALU_* funct3 encodings live in the shared include. No local literals are used.
- Sub-module alu_issue_skid is a generic payload-width 2-entry buffer with flush. It is instantiated only under ALU_ISSUE_SKID_EN.
- Operand selection and the bypass are combinational logic in alu_issue ahead of the register.

## Test plan
- OP SUB: rs1_val=5, rs2_val=7, funct7b5=1, funct3=000 → next cycle op1=5, op2=7, funct3=000, is_sub_sra=1.
- ADDI with funct7b5=1 (imm bit 10 set) → is_sub_sra=0. SRAI with funct7b5=1 → is_sub_sra=1, op2=imm.
- Bypass: in_rs1=3, in_rs1_val=1, wb_en=1, wb_rd=3, wb_data=0xDEADBEEF → op1=0xDEADBEEF. The same case with rs1=0 → op1=0.
- Backpressure: stream 4 instructions with out_ready low for 3 cycles. All 4 must emerge in order with none lost or duplicated, and in_ready must drop after 1 accept (macro off) or 2 accepts (macro on).
- Flush while full with in_valid=1 → next cycle out_valid=0 and the offered instruction is not accepted. AUIPC pc=0x100, imm=0x2000 later yields op1=0x100, op2=0x2000.
- Unknown opcode 0x7F → out_illegal=1, out_rd=0. Assert rst mid-stream → out_valid=0 immediately, then in_ready=1 after release.
